// File: rtl/fpu_job_ctl.sv
// Job controller around the fpu core: gathers four operands from a word stream,
// pulses the core start, captures its result (or a watchdog error) and streams it out.
module fpu_job_ctl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [31:0] fpu_c,
  output logic [31:0] fpu_d,
  output logic        fpu_en,
  input  logic        fpu_fi,
  input  logic [31:0] fpu_g,
  output logic [31:0] m_data,
  output logic        m_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    WAIT,
    OUT
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [1:0]  cnt;
  logic [15:0] tmo;
  logic        s_hs;
  logic        tmo_hit;

  assign s_hs    = s_valid & s_ready;
  assign tmo_hit = (tmo == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = LOAD;
      LOAD: if (s_hs && cnt == 2'd3) state_nx = RUN;
      RUN:  state_nx = WAIT;
      WAIT: if (fpu_fi || tmo_hit) state_nx = OUT;
      OUT:  if (m_ready) state_nx = LOAD;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs come straight from the registered state.
  always_comb begin
    s_ready = (state == LOAD);
    fpu_en  = (state == RUN);
    m_valid = (state == OUT);
    busy    = (state == RUN) || (state == WAIT) || (state == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      tmo    <= '0;
      fpu_a  <= '0;
      fpu_b  <= '0;
      fpu_c  <= '0;
      fpu_d  <= '0;
      m_data <= '0;
      m_err  <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (s_hs) begin
            case (cnt)
              2'd0:    fpu_a <= s_data;
              2'd1:    fpu_b <= s_data;
              2'd2:    fpu_c <= s_data;
              default: fpu_d <= s_data;
            endcase
            cnt <= cnt + 2'd1;
          end
        end
        RUN: tmo <= '0;
        WAIT: begin
          tmo <= tmo + 16'd1;
          // A finish pulse in the same cycle as the timeout still yields a good result.
          if (fpu_fi) begin
            m_data <= fpu_g;
            m_err  <= 1'b0;
          end else if (tmo_hit) begin
            m_data <= '0;
            m_err  <= 1'b1;
          end
        end
        OUT: if (m_ready) m_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_job_ctl.sv
// Randomized self-checking bench for fpu_job_ctl; a behavioural core model answers
// fpu_en after a chosen delay and the expected result/latency follow from that delay.
module tb_fpu_job_ctl;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] fpu_a, fpu_b, fpu_c, fpu_d;
  logic        fpu_en;
  logic        fpu_fi;
  logic [31:0] fpu_g;
  logic [31:0] m_data;
  logic        m_err;
  logic        m_valid;
  logic        m_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int fi_delay = 0;
  logic [31:0] fi_g = '0;

  fpu_job_ctl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_c(fpu_c), .fpu_d(fpu_d), .fpu_en(fpu_en),
    .fpu_fi(fpu_fi), .fpu_g(fpu_g), .m_data(m_data), .m_err(m_err),
    .m_valid(m_valid), .m_ready(m_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Core model: answers a start pulse fi_delay cycles later (0 = never answers).
  initial begin
    fpu_fi = 1'b0;
    fpu_g  = '0;
    forever begin
      @(posedge clk); #1;
      if (fpu_en === 1'b1 && fi_delay > 0) begin
        repeat (fi_delay) @(posedge clk);
        #1; fpu_fi = 1'b1; fpu_g = fi_g;
        @(posedge clk); #1; fpu_fi = 1'b0; fpu_g = $urandom;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  task automatic wait_ready(input string nm);
    int n = 0;
    while (s_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    tests++;
    if (s_ready !== 1'b1) begin
      fails++; $display("FAIL %s_wait_ready: s_ready=%b want 1", nm, s_ready);
    end
  endtask

  // gapmode: 0 none, 1 random idle cycles, 2 one idle cycle before every word.
  task automatic load_job(input logic [127:0] ops, input int gapmode, input bit fi_in_load,
                          input string nm);
    wait_ready(nm);
    for (int i = 0; i < 4; i++) begin
      if (gapmode == 2 || (gapmode == 1 && $urandom_range(1, 0) == 1)) begin
        s_valid = 1'b0; s_data = $urandom;
        fpu_fi = fi_in_load; fpu_g = $urandom;
        @(posedge clk); #1; fpu_fi = 1'b0;
        tests++;
        if (s_ready !== 1'b1 || fpu_en !== 1'b0) begin
          fails++; $display("FAIL %s_gap: s_ready=%b fpu_en=%b want 1/0", nm, s_ready, fpu_en);
        end
      end
      s_valid = 1'b1; s_data = ops[127-32*i -: 32];
      @(posedge clk); #1;
      if (i < 3) begin
        tests++;
        if (s_ready !== 1'b1 || fpu_en !== 1'b0) begin
          fails++; $display("FAIL %s_load%0d: s_ready=%b fpu_en=%b want 1/0", nm, i, s_ready, fpu_en);
        end
      end
    end
    s_valid = 1'b0; s_data = $urandom;
  endtask

  // Called in the RUN cycle (one cycle after d was accepted).
  task automatic finish_job(input logic [127:0] ops, input int k, input logic [31:0] g,
                            input int hold, input string nm);
    int n;
    int exp_n;
    bit ok_res;
    logic [31:0] exp_d;
    logic exp_e;
    ok_res = (k >= 1 && k <= int'(TMO));
    exp_d  = ok_res ? g : 32'h0;
    exp_e  = !ok_res;
    exp_n  = ok_res ? k + 1 : int'(TMO) + 1;
    tests++;
    if (fpu_en !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b1 || m_valid !== 1'b0) begin
      fails++; $display("FAIL %s_run: en=%b s_ready=%b busy=%b m_valid=%b want 1/0/1/0",
                        nm, fpu_en, s_ready, busy, m_valid);
    end
    tests++;
    if ({fpu_a, fpu_b, fpu_c, fpu_d} !== ops) begin
      fails++; $display("FAIL %s_operands: got %h want %h", nm, {fpu_a, fpu_b, fpu_c, fpu_d}, ops);
    end
    n = 0;
    while (n < int'(TMO) + 20) begin
      @(posedge clk); #1; n++;
      if (m_valid === 1'b1) break;
      tests++;
      if (fpu_en !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b0 ||
          {fpu_a, fpu_b, fpu_c, fpu_d} !== ops) begin
        fails++; $display("FAIL %s_wait: en=%b busy=%b s_ready=%b ops=%h want 0/1/0 %h",
                          nm, fpu_en, busy, s_ready, {fpu_a, fpu_b, fpu_c, fpu_d}, ops);
      end
    end
    tests++;
    if (m_valid !== 1'b1 || n != exp_n) begin
      fails++; $display("FAIL %s_latency: m_valid=%b after %0d cycles, want 1 after %0d",
                        nm, m_valid, n, exp_n);
    end
    tests++;
    if (m_data !== exp_d || m_err !== exp_e) begin
      fails++; $display("FAIL %s_result: data=%h err=%b want %h/%b", nm, m_data, m_err, exp_d, exp_e);
    end
    m_ready = 1'b0;
    if (!ok_res) begin
      fpu_fi = 1'b1; fpu_g = $urandom | 32'h1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1; fpu_fi = 1'b0;
      tests++;
      if (m_valid !== 1'b1 || m_data !== exp_d || m_err !== exp_e || s_ready !== 1'b0 ||
          busy !== 1'b1) begin
        fails++; $display("FAIL %s_hold%0d: valid=%b data=%h err=%b s_ready=%b want 1/%h/%b/0",
                          nm, i, m_valid, m_data, m_err, s_ready, exp_d, exp_e);
      end
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0; fpu_fi = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || m_err !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
      fails++; $display("FAIL %s_release: valid=%b err=%b s_ready=%b busy=%b want 0/0/1/0",
                        nm, m_valid, m_err, s_ready, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #12;
    tests++;
    if ({fpu_a, fpu_b, fpu_c, fpu_d, m_data} !== '0 ||
        {s_ready, fpu_en, m_valid, m_err, busy} !== 5'b0) begin
      fails++; $display("FAIL reset_values: ops=%h m_data=%h flags=%b want 0",
                        {fpu_a, fpu_b, fpu_c, fpu_d}, m_data, {s_ready, fpu_en, m_valid, m_err, busy});
    end
    @(posedge clk); #1; rst = 1'b0;
    tests++;
    if (s_ready !== 1'b0) begin
      fails++; $display("FAIL reset_idle: s_ready=%b want 0", s_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (s_ready !== 1'b1) begin
      fails++; $display("FAIL reset_load: s_ready=%b want 1", s_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [127:0] ops = {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    fi_delay = 5; fi_g = 32'h41200000;
    load_job(ops, 0, 1'b0, "b2b");
    finish_job(ops, 5, 32'h41200000, 0, "b2b");
  endtask

  task automatic test_backpressure;
    logic [127:0] ops = {$urandom, $urandom, $urandom, $urandom};
    fi_delay = 2; fi_g = $urandom;
    load_job(ops, 0, 1'b0, "bp");
    finish_job(ops, 2, fi_g, 10, "bp");
  endtask

  task automatic test_timeout;
    logic [127:0] ops = {$urandom, $urandom, $urandom, $urandom};
    fi_delay = 0;
    load_job(ops, 0, 1'b0, "tmo");
    finish_job(ops, 0, 32'h0, 3, "tmo");
    // Edge of the window: answer on the last WAIT cycle, then one cycle too late.
    for (int k = int'(TMO); k <= int'(TMO) + 1; k++) begin
      ops = {$urandom, $urandom, $urandom, $urandom};
      fi_delay = k; fi_g = $urandom;
      load_job(ops, 0, 1'b0, "tmo_edge");
      finish_job(ops, k, fi_g, 2, "tmo_edge");
    end
  endtask

  task automatic test_gapped;
    logic [127:0] ops = {$urandom, $urandom, $urandom, $urandom};
    fi_delay = 1; fi_g = $urandom;
    load_job(ops, 2, 1'b1, "gap");
    finish_job(ops, 1, fi_g, 1, "gap");
  endtask

  task automatic test_random;
    for (int j = 0; j < 30; j++) begin
      logic [127:0] ops = {$urandom, $urandom, $urandom, $urandom};
      int k = $urandom_range(int'(TMO) + 3, 0);
      fi_delay = k; fi_g = $urandom;
      load_job(ops, 1, 1'($urandom_range(1, 0)), "rnd");
      finish_job(ops, k, fi_g, $urandom_range(4, 0), "rnd");
    end
  endtask

  // Reset asserted in RUN (sc 0), WAIT (sc 1) and OUT (sc 2), then a fresh job.
  task automatic test_reset_mid;
    for (int sc = 0; sc < 3; sc++) begin
      logic [127:0] ops = {$urandom | 32'h1, $urandom, $urandom, $urandom | 32'h1};
      int n = 0;
      fi_delay = (sc == 2) ? 3 : 0; fi_g = $urandom | 32'h1;
      load_job(ops, 0, 1'b0, "rstmid");
      if (sc == 1) repeat (3) begin @(posedge clk); #1; end
      if (sc == 2) while (m_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({fpu_a, fpu_b, fpu_c, fpu_d, m_data} !== '0 ||
          {s_ready, fpu_en, m_valid, m_err, busy} !== 5'b0) begin
        fails++; $display("FAIL rstmid%0d_values: ops=%h m_data=%h flags=%b want 0",
                          sc, {fpu_a, fpu_b, fpu_c, fpu_d}, m_data, {s_ready, fpu_en, m_valid, m_err, busy});
      end
      @(posedge clk); #1; rst = 1'b0;
      tests++;
      if (s_ready !== 1'b0) begin
        fails++; $display("FAIL rstmid%0d_idle: s_ready=%b want 0", sc, s_ready);
      end
      @(posedge clk); #1;
      tests++;
      if (s_ready !== 1'b1) begin
        fails++; $display("FAIL rstmid%0d_load: s_ready=%b want 1", sc, s_ready);
      end
      ops = {$urandom, $urandom, $urandom, $urandom};
      fi_delay = 2; fi_g = $urandom;
      load_job(ops, 1, 1'b0, "rstfresh");
      finish_job(ops, 2, fi_g, 1, "rstfresh");
    end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_backpressure;
    test_timeout;
    test_gapped;
    test_random;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_job_ctl.md
# fpu_job_ctl

Job controller that sits in front of and behind the `fpu` core. It collects four 32-bit operands from a single-word valid/ready input stream and presents them on the core's `a`/`b`/`c`/`d` inputs. It then starts the core with a one-cycle `en` pulse, captures `g` when the core pulses `fi`, and returns the result on a valid/ready output stream. A watchdog converts a missing `fi` into an error-flagged result so the stream never stalls.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in WAIT before an error result is produced. Legal range 2..65535.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `s_data` input 32: operand word. Arrival order is a, b, c, d.
- `s_valid` input 1: `s_data` is valid.
- `s_ready` output 1: the block will accept `s_data` this cycle.
- `fpu_a`, `fpu_b`, `fpu_c`, `fpu_d` output 32 each: registered operands to the core.
- `fpu_en` output 1: one-cycle start pulse to the core.
- `fpu_fi` input 1: one-cycle finish pulse from the core; `fpu_g` is valid in that cycle.
- `fpu_g` input 32: core result.
- `m_data` output 32: result word.
- `m_err` output 1: set with `m_valid` when the result came from a timeout.
- `m_valid` output 1: `m_data`/`m_err` are valid.
- `m_ready` input 1: downstream accepts the result.
- `busy` output 1: high in RUN, WAIT and OUT.

## Operation
- States: IDLE, LOAD, RUN, WAIT, OUT.
- Reset values: state IDLE; `cnt`=0; `fpu_a`..`fpu_d`=0; `m_data`=0; `s_ready`, `fpu_en`, `m_valid`, `m_err` and `busy` all 0.
- IDLE: moves unconditionally to LOAD on the next clock. This gives `s_ready`=0 for at least one cycle after reset release.
- LOAD:
  - `s_ready`=1.
  - On each handshake (`s_valid`&&`s_ready`), store `s_data` into operand register `cnt` (0=a … 3=d) and increment the 2-bit `cnt`.
  - The handshake that stores d wraps `cnt` to 0 and moves the state to RUN.
  - No handshake in a cycle means no change.
- RUN: `fpu_en`=1 for exactly this one cycle; the next state is always WAIT.
- WAIT:
  - A timeout counter `tmo` starts at 0 on entry and increments each cycle.
  - If `fpu_fi`=1: capture `fpu_g` into `m_data`, set `m_err`=0 and go to OUT.
  - Else, if `tmo`==`TIMEOUT`-1: set `m_data`=0, `m_err`=1 and go to OUT.
  - When `fpu_fi`=1 and the timeout occur in the same cycle, `fpu_fi` wins.
- OUT:
  - `m_valid`=1, with `m_data`/`m_err` held stable until `m_ready`=1.
  - On the handshake, go to LOAD. `m_valid` drops in the next cycle and `m_err` clears.
- `fpu_fi` is ignored in every state except WAIT. A late `fi` that arrives after a timeout is discarded.
- Operand registers hold their values from the store of d until they are overwritten by the next job's loads. The core sees stable operands throughout RUN and WAIT.
- `s_ready`, `m_valid`, `fpu_en` and `busy` are decoded directly from the registered state (no combinational path from inputs to outputs).
- Asynchronous reset asserted in any state immediately forces all reset values:
  - a partially loaded job is lost;
  - a pending result is dropped;
  - `fpu_en` deasserts even mid-pulse.

## Timing
- Cycle L: d is accepted. Cycle L+1: RUN with `fpu_en`=1. Cycle L+2: first WAIT cycle.
- If `fpu_fi` arrives in cycle F≥L+2, `m_valid` is high from F+1.
- Minimum job latency: L+3 for `m_valid`, assuming the core returns `fi` one cycle after `en`.
- Timeout without `fi`: `m_valid` is high at cycle L+2+`TIMEOUT`.
- If `m_ready` is already high in the first OUT cycle, the result is consumed in that cycle and `s_ready` rises in the next cycle.
- Maximum throughput is one job per 7 cycles with a 1-cycle core: 4 load, 1 RUN, 1 WAIT, 1 OUT.

## Test plan
- Back-to-back load: drive `s_valid` high continuously with 0x3F800000, 0x40000000, 0x40400000, 0x40800000.
  - `fpu_a`..`fpu_d` equal these words in that order.
  - `fpu_en` is high exactly one cycle, one cycle after the fourth accept.
- Normal completion: bench model pulses `fpu_fi` 5 cycles after `fpu_en` with `fpu_g`=0x41200000.
  - `m_valid` rises the next cycle with `m_data`=0x41200000 and `m_err`=0.
- Backpressure on output: hold `m_ready`=0 for 10 cycles.
  - `m_valid`/`m_data` stay stable; `s_ready` stays 0.
  - Raising `m_ready` completes the handshake and returns the block to LOAD.
- Timeout: `TIMEOUT`=8, model never pulses `fi`.
  - `m_valid` is high 8 cycles after the first WAIT cycle, with `m_err`=1 and `m_data`=0.
  - A `fi` injected afterwards is ignored.
- Gapped input: toggle `s_valid` 1/0 every cycle.
  - Exactly four words are stored, with no duplicates.
  - `fi` pulsed during LOAD has no effect.
- Reset mid-job: assert `rst` in WAIT and in OUT.
  - All outputs take reset values asynchronously.
  - After release there is one IDLE cycle, then `s_ready`=1 and a fresh job completes correctly.
